// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: opcodes, bundle widths and the MEM-stage
// state encoding used by the MEM/WB slice.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {
    MEM_EMPTY = 2'd0,
    MEM_ALU   = 2'd1,
    MEM_WAIT  = 2'd2
  } mem_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  misaligned;
  } mem_reg_t;

  function automatic logic is_misaligned(input logic [DATA_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_wait_timer.sv
// Counts unacknowledged data-memory request cycles and flags the cycle in which
// the access has waited MEM_TIMEOUT cycles and must be abandoned.
module dmem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The MEM_TIMEOUT-th waiting cycle is the last one the request stays high.
  assign expire_o = count_i && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB stages: performs lw/sw over a req/ack data port, holds the MEM/WB
// register that drives the register-file write port, and exports hazard info.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_W-1:0]     ex_alu_result_i,
  input  logic [DATA_W-1:0]     ex_store_data_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  ex_reg_write_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_mem_write_i,
  input  logic                  ex_mem_to_reg_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [DATA_W-1:0]     dmem_addr_o,
  output logic [DATA_W-1:0]     dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [DATA_W-1:0]     dmem_rdata_i,
  output logic                  wb_reg_write_o,
  output logic [REG_ADDR_W-1:0] wb_rd_addr_o,
  output logic [DATA_W-1:0]     wb_rd_data_o,
  output logic                  m_fwd_valid_o,
  output logic [REG_ADDR_W-1:0] m_rd_addr_o,
  output logic                  m_load_pending_o,
  output logic                  err_o
);

  mem_state_e            state_q, state_d;
  mem_reg_t              m_q, m_d;
  logic                  wb_we_q, wb_we_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  err_q, err_d;

  logic in_wait, acked, abort, m_complete, accept, new_mem_op, new_misaligned;

  assign in_wait        = (state_q == MEM_WAIT);
  assign acked          = in_wait & dmem_ack_i;
  assign m_complete     = (state_q == MEM_ALU) | acked | abort;
  assign ex_ready_o     = rst_n_i & ((state_q == MEM_EMPTY) | m_complete);
  assign accept         = ex_valid_i & ex_ready_o;
  assign new_mem_op     = ex_mem_read_i | ex_mem_write_i;
  assign new_misaligned = new_mem_op & is_misaligned(ex_alu_result_i);

  dmem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (m_complete | accept),
    .count_i (in_wait & ~dmem_ack_i),
    .expire_o(abort)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= MEM_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Misaligned accesses never reach memory; they retire from the ALU state.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (new_mem_op && !new_misaligned) ? MEM_WAIT : MEM_ALU;
    end else if (m_complete) begin
      state_d = MEM_EMPTY;
    end
  end

  always_comb begin
    dmem_req_o       = in_wait;
    dmem_we_o        = in_wait & m_q.mem_write;
    dmem_addr_o      = m_q.alu_result;
    dmem_wdata_o     = m_q.store_data;
    m_fwd_valid_o    = (state_q == MEM_ALU) & m_q.reg_write & (m_q.rd != '0) & ~m_q.misaligned;
    m_rd_addr_o      = (state_q == MEM_EMPTY) ? '0 : m_q.rd;
    m_load_pending_o = in_wait & m_q.mem_read;
  end

  always_comb begin
    m_d = m_q;
    if (accept) begin
      m_d.alu_result = ex_alu_result_i;
      m_d.store_data = ex_store_data_i;
      m_d.rd         = ex_rd_addr_i;
      m_d.reg_write  = ex_reg_write_i;
      m_d.mem_read   = ex_mem_read_i;
      m_d.mem_write  = ex_mem_write_i;
      m_d.mem_to_reg = ex_mem_to_reg_i;
      m_d.misaligned = new_misaligned;
    end
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    if (m_complete) begin
      wb_rd_d   = m_q.rd;
      wb_data_d = m_q.mem_to_reg ? dmem_rdata_i : m_q.alu_result;
      wb_we_d   = m_q.reg_write & ~m_q.mem_write & (m_q.rd != '0) & ~m_q.misaligned & ~abort;
    end
    err_d = err_q | (accept & new_misaligned) | abort;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_q       <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      m_q       <= m_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign wb_reg_write_o = wb_we_q;
  assign wb_rd_addr_o   = wb_rd_q;
  assign wb_rd_data_o   = wb_data_q;
  assign err_o          = err_q;

endmodule
